// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 3-bit select-code sequencer with dwell, sweep and manual-step modes
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               start,
    input  logic               step,
    output logic [2:0]         code,
    output logic               code_valid,
    output logic               sweep_done,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_MANUAL = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [2:0]         code_q, code_d;
    logic               code_valid_q, code_valid_d;
    logic               sweep_done_q, sweep_done_d;
    logic               busy_q, busy_d;

    logic               trigger;
    logic [2:0]         last_code;
    logic [2:0]         next_code;
    logic               at_last;
    logic               dwell_hit;

    // Entry condition, end-of-sweep code and the 3-bit modular advance (wraps LAST to FIRST on its own)
    always_comb begin
        trigger   = en && ((mode == MODE_CONT) || (mode == MODE_MANUAL) ||
                           ((mode == MODE_SINGLE) && start));
        last_code = dir_q ? 3'b000 : 3'b111;
        next_code = dir_q ? (code_q - 3'd1) : (code_q + 3'd1);
        at_last   = (code_q == last_code);
        dwell_hit = (dwell_cnt_q == dwell_q);
    end

    // Next-state and registered-output logic; abort outranks any advance in the same cycle
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        dir_d        = dir_q;
        dwell_d      = dwell_q;
        dwell_cnt_d  = dwell_cnt_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        sweep_done_d = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d      = SCAN;
                    mode_d       = mode;
                    dir_d        = dir;
                    dwell_d      = dwell;
                    dwell_cnt_d  = '0;
                    code_d       = dir ? 3'b111 : 3'b000;
                    code_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SCAN: begin
                if (!en || (mode != mode_q)) begin
                    state_d      = IDLE;
                    code_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end else if (mode_q == MODE_MANUAL) begin
                    if (step) begin
                        code_d       = next_code;
                        sweep_done_d = at_last;
                    end
                end else if (dwell_hit) begin
                    dwell_cnt_d  = '0;
                    sweep_done_d = at_last;
                    if (at_last && (mode_q == MODE_SINGLE)) begin
                        state_d      = IDLE;
                        code_valid_d = 1'b0;
                        busy_d       = 1'b0;
                    end else begin
                        code_d = next_code;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 2'b00;
            dir_q        <= 1'b0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            code_q       <= 3'b000;
            code_valid_q <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            sweep_done_q <= sweep_done_d;
            busy_q       <= busy_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign sweep_done = sweep_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed table and sequence checks for scan_sequencer
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic [7:0] dwell;
    logic       start;
    logic       step;
    logic [2:0] code;
    logic       code_valid;
    logic       sweep_done;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .dir        (dir),
        .dwell      (dwell),
        .start      (start),
        .step       (step),
        .code       (code),
        .code_valid (code_valid),
        .sweep_done (sweep_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       dir;
        logic [7:0] dwell;
        logic       start;
        logic       step;
        logic [2:0] e_code;
        logic       e_valid;
        logic       e_done;
        logic       e_busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic e, logic [1:0] m, logic d, logic [7:0] dw, logic s, logic st,
                                logic [2:0] c, logic v, logic dn, logic b);
        vec_t r;
        r.en = e; r.mode = m; r.dir = d; r.dwell = dw; r.start = s; r.step = st;
        r.e_code = c; r.e_valid = v; r.e_done = dn; r.e_busy = b;
        return r;
    endfunction

    task automatic drive(logic e, logic [1:0] m, logic d, logic [7:0] dw, logic s, logic st);
        en = e; mode = m; dir = d; dwell = dw; start = s; step = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [2:0] c, logic v, logic dn, logic b);
        compared++;
        if ({code, code_valid, sweep_done, busy} !== {c, v, dn, b}) begin
            mismatched++;
            $display("FAIL %s: got code=%b valid=%b done=%b busy=%b, want code=%b valid=%b done=%b busy=%b",
                     nm, code, code_valid, sweep_done, busy, c, v, dn, b);
        end
    endtask

    initial begin
        // single sweep down, dwell 0, with a repeated start mid-sweep
        vt.push_back(mk(1, 2'b10, 1, 0, 0, 0, 3'd0, 0, 0, 0));
        vt.push_back(mk(1, 2'b10, 1, 0, 1, 0, 3'd7, 1, 0, 1));
        vt.push_back(mk(1, 2'b10, 1, 0, 0, 0, 3'd6, 1, 0, 1));
        vt.push_back(mk(1, 2'b10, 1, 0, 1, 0, 3'd5, 1, 0, 1));
        for (int i = 4; i >= 0; i--)
            vt.push_back(mk(1, 2'b10, 1, 0, 0, 0, 3'(i), 1, 0, 1));
        vt.push_back(mk(1, 2'b10, 1, 0, 0, 0, 3'd0, 0, 1, 0));
        vt.push_back(mk(1, 2'b10, 1, 0, 0, 0, 3'd0, 0, 0, 0));
        // manual up: entry step ignored, then 10 steps end at 010
        vt.push_back(mk(1, 2'b11, 0, 0, 0, 1, 3'd0, 1, 0, 1));
        for (int i = 1; i <= 10; i++)
            vt.push_back(mk(1, 2'b11, 0, 0, 0, 1, 3'(i % 8), 1, (i == 8), 1));
        vt.push_back(mk(1, 2'b11, 0, 0, 0, 0, 3'd2, 1, 0, 1));
        // mode change aborts, then idle with en low
        vt.push_back(mk(1, 2'b01, 0, 0, 0, 0, 3'd2, 0, 0, 0));
        vt.push_back(mk(0, 2'b01, 0, 0, 0, 0, 3'd2, 0, 0, 0));

        rst_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_state", 3'd0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].mode, vt[i].dir, vt[i].dwell, vt[i].start, vt[i].step);
            tick();
            chk($sformatf("vec%0d", i), vt[i].e_code, vt[i].e_valid, vt[i].e_done, vt[i].e_busy);
        end

        // continuous up, dwell 2; dwell/dir changes mid-sweep must not take effect
        drive(1, 2'b01, 0, 8'd2, 0, 0);
        tick();
        for (int k = 0; k < 30; k++) begin
            if (k > 0) tick();
            chk($sformatf("cont_k%0d", k), 3'((k / 3) % 8), 1, (k == 24), 1);
            if (k == 5) begin
                dir   = 1'b1;
                dwell = 8'd5;
            end
        end
        mode = 2'b11;
        tick();
        chk("mode_chg_abort", 3'd1, 0, 0, 0);
        en = 1'b0;
        tick();

        // abort at 101, restart at 000, then abort coinciding with the wrap
        drive(1, 2'b01, 0, 8'd0, 0, 0);
        tick();
        chk("abort_entry", 3'd0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) tick();
        chk("abort_at5_pre", 3'd5, 1, 0, 1);
        en = 1'b0;
        tick();
        chk("abort_at5", 3'd5, 0, 0, 0);
        en = 1'b1;
        tick();
        chk("restart", 3'd0, 1, 0, 1);
        for (int i = 1; i <= 7; i++) tick();
        chk("abort_at7_pre", 3'd7, 1, 0, 1);
        en = 1'b0;
        tick();
        chk("abort_over_wrap", 3'd7, 0, 0, 0);

        // asynchronous reset mid-sweep at code 011
        drive(1, 2'b01, 0, 8'd0, 0, 0);
        tick();
        tick();
        tick();
        tick();
        chk("pre_reset", 3'd3, 1, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 3'd0, 0, 0, 0);
        #2 rst_n = 1'b1;
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_reset_idle%0d", i), 3'd0, 0, 0, 0);
        end
        mode = 2'b01;
        tick();
        chk("post_reset_trigger", 3'd0, 1, 0, 1);
        en = 1'b0;
        tick();

        // dwell all-ones holds each code 256 cycles
        drive(1, 2'b01, 0, 8'hFF, 0, 0);
        tick();
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 255) chk("dwell_max_hold", 3'd0, 1, 0, 1);
            if (k == 256) chk("dwell_max_adv", 3'd1, 1, 0, 1);
        end
        en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
